// File: rtl/pe_window_sequencer.sv
// Scanline sequencer producing per-pixel WIN0/WIN1 flags for the window masker.
// Optional macro WIN_SHADOW_EN: latch window/enable registers at line_start.
module pe_window_sequencer #(
  parameter int H_VISIBLE = 240,
  parameter int V_VISIBLE = 160
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [7:0]  vcount,
  input  logic        pixel_en,
  input  logic [15:0] dispcnt,
  input  logic [15:0] win0h,
  input  logic [15:0] win0v,
  input  logic [15:0] win1h,
  input  logic [15:0] win1v,
  output logic        win0,
  output logic        win1,
  output logic [7:0]  pix_x,
  output logic        pix_valid,
  output logic        line_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] X_LAST  = 8'(H_VISIBLE - 1);
  localparam logic [7:0] V_LIMIT = 8'(V_VISIBLE);

  // Half-open interval test with wrap-around; lo == hi is an empty window.
  function automatic logic range_hit(input logic [7:0] lo, input logic [7:0] hi,
                                     input logic [7:0] v);
    logic hit_s;
    if (lo == hi) begin
      hit_s = 1'b0;
    end else if (lo < hi) begin
      hit_s = (v >= lo) && (v < hi);
    end else begin
      hit_s = (v >= lo) || (v < hi);
    end
    return hit_s;
  endfunction

  state_t     state_r;
  logic [7:0] x_r;
  logic       vin0_r;
  logic       vin1_r;
  logic       win0_r;
  logic       win1_r;
  logic [7:0] pix_x_r;
  logic       pix_valid_r;
  logic       line_done_r;

  logic [15:0] win0h_s;
  logic [15:0] win1h_s;
  logic [1:0]  en_s;
  logic        unused_dispcnt_s;

  assign unused_dispcnt_s = ^{dispcnt[15], dispcnt[12:0]};

`ifdef WIN_SHADOW_EN
  logic [15:0] win0h_sh_r;
  logic [15:0] win1h_sh_r;
  logic [1:0]  en_sh_r;

  // Shadow copies of horizontal bounds and enables, refreshed once per line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win0h_sh_r <= 16'h0000;
      win1h_sh_r <= 16'h0000;
      en_sh_r    <= 2'b00;
    end else if (line_start) begin
      win0h_sh_r <= win0h;
      win1h_sh_r <= win1h;
      en_sh_r    <= dispcnt[14:13];
    end else begin
      win0h_sh_r <= win0h_sh_r;
      win1h_sh_r <= win1h_sh_r;
      en_sh_r    <= en_sh_r;
    end
  end

  assign win0h_s = win0h_sh_r;
  assign win1h_s = win1h_sh_r;
  assign en_s    = en_sh_r;
`else
  assign win0h_s = win0h;
  assign win1h_s = win1h;
  assign en_s    = dispcnt[14:13];
`endif

  // Line FSM: line_start always wins, aborting any line in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      x_r         <= 8'd0;
      vin0_r      <= 1'b0;
      vin1_r      <= 1'b0;
      win0_r      <= 1'b0;
      win1_r      <= 1'b0;
      pix_x_r     <= 8'd0;
      pix_valid_r <= 1'b0;
      line_done_r <= 1'b0;
    end else begin
      pix_valid_r <= 1'b0;
      line_done_r <= 1'b0;
      if (line_start) begin
        x_r     <= 8'd0;
        vin0_r  <= range_hit(win0v[15:8], win0v[7:0], vcount);
        vin1_r  <= range_hit(win1v[15:8], win1v[7:0], vcount);
        state_r <= (vcount < V_LIMIT) ? ST_ACTIVE : ST_IDLE;
      end else begin
        case (state_r)
          ST_ACTIVE: begin
            if (pixel_en) begin
              pix_valid_r <= 1'b1;
              pix_x_r     <= x_r;
              win0_r      <= en_s[0] & vin0_r & range_hit(win0h_s[15:8], win0h_s[7:0], x_r);
              win1_r      <= en_s[1] & vin1_r & range_hit(win1h_s[15:8], win1h_s[7:0], x_r);
              if (x_r == X_LAST) begin
                x_r     <= 8'd0;
                state_r <= ST_DONE;
              end else begin
                x_r     <= x_r + 8'd1;
              end
            end else begin
              state_r <= ST_ACTIVE;
            end
          end
          ST_DONE: begin
            line_done_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign win0      = win0_r;
  assign win1      = win1_r;
  assign pix_x     = pix_x_r;
  assign pix_valid = pix_valid_r;
  assign line_done = line_done_r;

endmodule

// File: tb/tb_pe_window_sequencer.sv
// Self-checking bench for pe_window_sequencer: directed scenarios plus randomized
// lines compared against a modular-arithmetic window model.
module tb_pe_window_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        line_start;
  logic [7:0]  vcount;
  logic        pixel_en;
  logic [15:0] dispcnt;
  logic [15:0] win0h;
  logic [15:0] win0v;
  logic [15:0] win1h;
  logic [15:0] win1v;
  logic        win0;
  logic        win1;
  logic [7:0]  pix_x;
  logic        pix_valid;
  logic        line_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_x;
  bit         m_act;
  bit         m_done;
  bit         m_v0;
  bit         m_v1;
  logic [15:0] m_h0;
  logic [15:0] m_h1;
  logic [1:0]  m_en;

  int cnt_w0, cnt_w1, cnt_valid, cnt_done;

  pe_window_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .line_start (line_start),
    .vcount     (vcount),
    .pixel_en   (pixel_en),
    .dispcnt    (dispcnt),
    .win0h      (win0h),
    .win0v      (win0v),
    .win1h      (win1h),
    .win1v      (win1v),
    .win0       (win0),
    .win1       (win1),
    .pix_x      (pix_x),
    .pix_valid  (pix_valid),
    .line_done  (line_done)
  );

  always #5 clock = ~clock;

  // A point v is inside [lo,hi) on the 256-wide ring when its offset from lo
  // is smaller than the ring length of the window.
  function automatic bit in_window(input int lo, input int hi, input int v);
    return ((v - lo + 256) % 256) < ((hi - lo + 256) % 256);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    cnt_w0 = 0; cnt_w1 = 0; cnt_valid = 0; cnt_done = 0;
  endtask

  task automatic model_reset();
    m_x = 0; m_act = 1'b0; m_done = 1'b0; m_v0 = 1'b0; m_v1 = 1'b0;
    m_h0 = 16'h0000; m_h1 = 16'h0000; m_en = 2'b00;
  endtask

  // One clock: predict from the inputs the DUT samples, then compare after the edge.
  task automatic tick(input bit ls, input bit pe);
    bit         e_valid, e_done, e_w0, e_w1;
    int         e_x;
    logic [15:0] h0, h1;
    logic [1:0]  en;
    e_valid = 1'b0; e_done = 1'b0; e_w0 = 1'b0; e_w1 = 1'b0; e_x = 0;
    line_start = ls;
    pixel_en   = pe;
    if (ls) begin
      m_v0   = in_window(win0v[15:8], win0v[7:0], vcount);
      m_v1   = in_window(win1v[15:8], win1v[7:0], vcount);
      m_x    = 0;
      m_act  = (vcount < 8'd160);
      m_done = 1'b0;
`ifdef WIN_SHADOW_EN
      m_h0 = win0h; m_h1 = win1h; m_en = dispcnt[14:13];
`endif
    end else if (m_done) begin
      e_done = 1'b1;
      m_done = 1'b0;
    end else if (m_act && pe) begin
`ifdef WIN_SHADOW_EN
      h0 = m_h0; h1 = m_h1; en = m_en;
`else
      h0 = win0h; h1 = win1h; en = dispcnt[14:13];
`endif
      e_valid = 1'b1;
      e_x     = m_x;
      e_w0    = en[0] && m_v0 && in_window(h0[15:8], h0[7:0], m_x);
      e_w1    = en[1] && m_v1 && in_window(h1[15:8], h1[7:0], m_x);
      if (m_x == 239) begin
        m_act = 1'b0; m_done = 1'b1;
      end else begin
        m_x++;
      end
    end
    @(posedge clock);
    #1;
    check("pix_valid", {15'd0, pix_valid}, {15'd0, e_valid});
    check("line_done", {15'd0, line_done}, {15'd0, e_done});
    if (e_valid) begin
      check("pix_x", {8'd0, pix_x}, 16'(e_x));
      check("win0", {15'd0, win0}, {15'd0, e_w0});
      check("win1", {15'd0, win1}, {15'd0, e_w1});
    end
    if (pix_valid === 1'b1) begin
      cnt_valid++;
      if (win0 === 1'b1) cnt_w0++;
      if (win1 === 1'b1) cnt_w1++;
    end
    if (line_done === 1'b1) cnt_done++;
    line_start = 1'b0;
    pixel_en   = 1'b0;
  endtask

  // Start a line and offer npix pixels; chg_at clears win0h before that pixel.
  task automatic run_line(input logic [7:0] vc, input int npix, input bit rnd, input int chg_at);
    int  sent = 0;
    int  cycles = 0;
    bit  pe;
    vcount = vc;
    tick(1'b1, 1'b0);
    vcount = 8'($urandom);
    while (sent < npix && cycles < 4000) begin
      pe = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      if (pe && sent == chg_at) win0h = 16'h0000;
      if (rnd && $urandom_range(31, 0) == 0) dispcnt = 16'($urandom);
      if (rnd && $urandom_range(31, 0) == 0) win1h = 16'($urandom);
      tick(1'b0, pe);
      if (pe) sent++;
      cycles++;
    end
    check("line_budget", 16'(cycles < 4000), 16'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; line_start = 1'b0; pixel_en = 1'b0; vcount = 8'd0;
    dispcnt = 16'h0000; win0h = 16'h0000; win0v = 16'h0000;
    win1h = 16'h0000; win1v = 16'h0000;
    model_reset();

    // T1: reset holds every output low regardless of pixel_en
    for (int i = 0; i < 4; i++) begin
      pixel_en = i[0];
      @(posedge clock);
      #1;
      check("rst_outs", {pix_x, 4'd0, win0, win1, pix_valid, line_done}, 16'h0000);
    end
    pixel_en = 1'b0;
    reset_n = 1'b1;
    idle(2);

    // T2: plain WIN0 rectangle
    win0h = 16'h1050; win0v = 16'h2040; dispcnt = 16'h2000;
    clr_counts();
    run_line(8'h30, 240, 1'b0, -1);
    idle(3);
    check("t2_w0_count", 16'(cnt_w0), 16'd64);
    check("t2_valid_count", 16'(cnt_valid), 16'd240);
    check("t2_done_count", 16'(cnt_done), 16'd1);

    // T3: WIN1 horizontal wrap-around
    win1h = 16'hC820; win1v = 16'h00A0; dispcnt = 16'h4000;
    clr_counts();
    run_line(8'd5, 240, 1'b0, -1);
    idle(3);
    check("t3_w1_count", 16'(cnt_w1), 16'd72);
    check("t3_w0_count", 16'(cnt_w0), 16'd0);

    // T4: line outside visible area
    clr_counts();
    run_line(8'hA0, 240, 1'b0, -1);
    idle(3);
    check("t4_valid_count", 16'(cnt_valid), 16'd0);
    check("t4_done_count", 16'(cnt_done), 16'd0);

    // T5: abort at pix_x=100 with a colliding pixel_en
    win0h = 16'h1050; win0v = 16'h2040; dispcnt = 16'h6000;
    clr_counts();
    run_line(8'h30, 101, 1'b0, -1);
    check("t5_last_x", {8'd0, pix_x}, 16'd100);
    vcount = 8'h31;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 240; i++) tick(1'b0, 1'b1);
    idle(3);
    check("t5_valid_count", 16'(cnt_valid), 16'd341);
    check("t5_done_count", 16'(cnt_done), 16'd1);

    // T6: mid-line write to win0h after pixel 50
    win0h = 16'h1050; win0v = 16'h2040; dispcnt = 16'h2000;
    clr_counts();
    run_line(8'h30, 240, 1'b0, 51);
    idle(2);
`ifdef WIN_SHADOW_EN
    check("t6_w0_count", 16'(cnt_w0), 16'd64);
`else
    check("t6_w0_count", 16'(cnt_w0), 16'd35);
`endif
    clr_counts();
    run_line(8'h30, 240, 1'b0, -1);
    idle(2);
    check("t6_next_w0_count", 16'(cnt_w0), 16'd0);

    // Randomized lines with gaps, random windows and occasional live writes
    for (int l = 0; l < 8; l++) begin
      win0h = 16'($urandom); win0v = 16'($urandom);
      win1h = 16'($urandom); win1v = 16'($urandom);
      dispcnt = 16'($urandom);
      if (l % 3 == 0) begin
        win0h = {win0h[15:8], win0h[15:8]};
      end
      run_line(8'($urandom_range(199, 0)), 240, 1'b1, -1);
      idle($urandom_range(3, 0));
    end

    // Asynchronous reset mid-line returns outputs to reset values at once
    win0h = 16'h0050; win0v = 16'h00FF; dispcnt = 16'h6000; win1h = 16'h00F0; win1v = 16'h00FF;
    run_line(8'd10, 60, 1'b0, -1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", {pix_x, 4'd0, win0, win1, pix_valid, line_done}, 16'h0000);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
